mm_result_reader: RTL and testbench
===================================

# mm_result_reader

Drains the banked result SRAM that the matrix-multiply engine fills, one full row per beat. Sits on the consumer side of the result memories. After the engine has written all ROW_NUM rows across the COL_NUM column banks, this block issues synchronous reads and reassembles each row into a COL_NUM-wide word. It then streams the rows out over a valid/ready interface with full backpressure support.

## Interface
Parameters:
- DATA_WIDTH, 8, bits per element
- ROW_NUM, 32, rows to drain per job
- COL_NUM, 32, number of result banks (elements per row)
- ROW_ADDR_WIDTH, $clog2(ROW_NUM), derived; not set manually

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  asynchronous, active-low; asserted (0) clears all state immediately
- start  in  1  begin a drain job; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the last row handshakes
- row_rdaddr  out  ROW_ADDR_WIDTH*COL_NUM  per-bank read address; all slices carry the same value
- row_rd_en  out  COL_NUM  per-bank read enable; all bits equal
- row_data_in  in  DATA_WIDTH*COL_NUM  bank read data, valid exactly 1 cycle after row_rd_en
- out_data  out  DATA_WIDTH*COL_NUM  row payload; bank i is at bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH]
- out_row  out  ROW_ADDR_WIDTH  row index of out_data
- out_last  out  1  high with row ROW_NUM-1
- out_val  out  1  payload valid
- out_rdy  in  1  consumer accepts; a transfer occurs when out_val & out_rdy

## Operation
- FSM states:
  - IDLE: start=1 loads rd_ptr=0 and moves to READ.
  - READ: issues reads; after issuing row ROW_NUM-1, moves to DRAIN.
  - DRAIN: waits for the last transfer, then pulses done and returns to IDLE.
- Read issue:
  - In READ, assert row_rd_en when (fifo_count + inflight) < 3. Use registered values only; there is no combinational path from out_rdy to row_rd_en.
  - On issue, row_rdaddr = rd_ptr, then rd_ptr increments.
  - inflight is a 1-bit flag: set on issue, cleared the next cycle.
- Capture:
  - On the cycle after an issue, push row_data_in into a 3-entry FIFO.
  - The FIFO push always succeeds; the credit rule guarantees the FIFO is never overrun.
  - The FIFO also carries the row index and the last flag with each entry.
- Output:
  - out_val = FIFO not empty; out_data, out_row and out_last come from the FIFO head.
  - The head holds stable while out_val=1 and out_rdy=0.
- Counters:
  - rd_ptr is ROW_ADDR_WIDTH+1 bits wide, so ROW_NUM reaching a power of two does not wrap.
  - out_row values are 0..ROW_NUM-1 in strict order, each exactly once per job.
- Boundaries:
  - start while busy is ignored.
  - A simultaneous push and pop leaves the FIFO count unchanged.
  - When the job completes, done is pulsed and the FIFO is empty.
  - Reset mid-job aborts the job: FSM→IDLE, FIFO flushed, counters zeroed. No done is produced for the aborted job.

## Timing
- Reset values: busy=0, done=0, out_val=0, out_last=0, row_rd_en=0, row_rdaddr=0, out_row=0, out_data=0.
- start high in cycle 0 gives:
  - busy=1 and first row_rd_en in cycle 1;
  - data in cycle 2;
  - out_val=1 with row 0 in cycle 3.
- With out_rdy held high, steady-state throughput is 1 row/cycle. The last transfer occurs in cycle ROW_NUM+2, and done pulses in cycle ROW_NUM+3.
- busy falls in the same cycle done pulses.
- A new start is accepted in the cycle after done.
- Under backpressure, at most 3 rows are buffered and reads stall with no loss or duplication.

## Structure
- Shared package mm_pkg holds:
  - the FSM state enum (IDLE, READ, DRAIN);
  - the FIFO depth constant RD_FIFO_DEPTH=3.
- Sub-module mm_row_fifo: a parameterised synchronous FIFO with width and depth parameters, push/pop, count, and async active-low reset. It is instantiated once, with width DATA_WIDTH*COL_NUM+ROW_ADDR_WIDTH+1.
- The top level contains the FSM, read-issue/credit logic, address replication across banks, and the inflight flag.

## Test plan
- Use ROW_NUM=4, COL_NUM=4 and a bank model where bank i stores the value 16*row+i; out_rdy is held at 1 unless stated otherwise.
- Basic drain: pulse start → out_row 0,1,2,3 in cycles 3–6 with out_data lanes {16r+3,16r+2,16r+1,16r}; out_last only on row 3; done in cycle 7.
- Backpressure: out_rdy=0 for cycles 3–10, then 1 → row_rd_en stops after 3 issues, row 0 is held stable through cycle 10, all 4 rows arrive in order, and done follows the last transfer.
- Alternating out_rdy (1,0,1,0…) → no row dropped or duplicated, fifo_count never exceeds 3, rows arrive in order 0–3.
- start asserted while busy (cycle 4) → ignored: exactly 4 rows and a single done; a start the cycle after done runs a second full job.
- Reset (0) in cycle 5 mid-job → all outputs return to reset values immediately; the next start drains rows 0–3 again from row 0.

Source files
------------

// File: rtl/mm_pkg.sv
// Shared types and constants for the matrix-multiply result reader.
package mm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } rd_state_t;

    localparam int RD_FIFO_DEPTH = 3;
    localparam int RD_FIFO_CNT_W = $clog2(RD_FIFO_DEPTH + 1);

endpackage

// File: rtl/mm_result_reader_if.sv
// Row stream leaving the result reader: one reassembled row per valid/ready beat.
interface mm_result_reader_if #(
    parameter int DATA_WIDTH     = 8,
    parameter int COL_NUM        = 32,
    parameter int ROW_ADDR_WIDTH = 5
);

    logic [DATA_WIDTH*COL_NUM-1:0] out_data;
    logic [ROW_ADDR_WIDTH-1:0]     out_row;
    logic                          out_last;
    logic                          out_val;
    logic                          out_rdy;

    modport master (
        output out_data,
        output out_row,
        output out_last,
        output out_val,
        input  out_rdy
    );

    modport slave (
        input  out_data,
        input  out_row,
        input  out_last,
        input  out_val,
        output out_rdy
    );

endinterface

// File: rtl/mm_row_fifo.sv
// Small synchronous FIFO with occupancy count; DEPTH need not be a power of two.
module mm_row_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             pop_ok;
    logic             push_ok;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign rdata   = mem[rd_ptr];

    // Storage is cleared on reset so an idle reader presents an all-zero head.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (pop_ok) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mm_result_reader.sv
// Drains the banked result SRAM row by row and streams each reassembled row
// out over valid/ready, throttling reads so at most three rows are ever pending.
module mm_result_reader
    import mm_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ROW_NUM    = 32,
    parameter int COL_NUM    = 32,
    localparam int ROW_ADDR_WIDTH = $clog2(ROW_NUM)
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    output logic                               busy,
    output logic                               done,
    output logic [ROW_ADDR_WIDTH*COL_NUM-1:0]  row_rdaddr,
    output logic [COL_NUM-1:0]                 row_rd_en,
    input  logic [DATA_WIDTH*COL_NUM-1:0]      row_data_in,
    mm_result_reader_if.master                 out_if
);

    localparam int ROW_W   = DATA_WIDTH * COL_NUM;
    localparam int ENTRY_W = ROW_W + ROW_ADDR_WIDTH + 1;

    rd_state_t                state;
    logic [ROW_ADDR_WIDTH:0]  rd_ptr;
    logic                     inflight;
    logic [ROW_ADDR_WIDTH-1:0] cap_row;
    logic                     cap_last;
    logic                     issue;
    logic                     is_last_row;
    logic [RD_FIFO_CNT_W:0]   pending;
    logic [RD_FIFO_CNT_W-1:0] fifo_count;
    logic [ENTRY_W-1:0]       fifo_wdata;
    logic [ENTRY_W-1:0]       fifo_rdata;
    logic                     fifo_empty;
    logic                     fifo_full;
    logic                     pop;

    // Credit counts only registered state, so out_rdy never reaches the read enables.
    assign pending     = {1'b0, fifo_count} + {{RD_FIFO_CNT_W{1'b0}}, inflight};
    assign issue       = (state == READ) && (pending < (RD_FIFO_CNT_W + 1)'(RD_FIFO_DEPTH));
    assign is_last_row = (rd_ptr == (ROW_ADDR_WIDTH + 1)'(ROW_NUM - 1));

    assign row_rd_en  = {COL_NUM{issue}};
    assign row_rdaddr = {COL_NUM{rd_ptr[ROW_ADDR_WIDTH-1:0]}};

    assign pop            = out_if.out_val && out_if.out_rdy;
    assign out_if.out_val = !fifo_empty;
    assign {out_if.out_last, out_if.out_row, out_if.out_data} = fifo_rdata;

    assign fifo_wdata = {cap_last, cap_row, row_data_in};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            rd_ptr <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        rd_ptr <= '0;
                        busy   <= 1'b1;
                        state  <= READ;
                    end
                end
                READ: begin
                    if (issue) begin
                        rd_ptr <= rd_ptr + 1'b1;
                        if (is_last_row) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && out_if.out_last) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Row index and last flag travel alongside the one-cycle read latency.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inflight <= 1'b0;
            cap_row  <= '0;
            cap_last <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                cap_row  <= rd_ptr[ROW_ADDR_WIDTH-1:0];
                cap_last <= is_last_row;
            end
        end
    end

    mm_row_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (RD_FIFO_DEPTH)
    ) u_row_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (inflight),
        .pop   (pop),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

endmodule

// File: tb/tb_mm_result_reader.sv
// Scoreboard bench for mm_result_reader with a 4x4 bank model (bank i holds 16*row+i).
module tb_mm_result_reader;

    localparam int DW  = 8;
    localparam int RN  = 4;
    localparam int CN  = 4;
    localparam int RAW = 2;

    typedef struct {
        int          row;
        logic [31:0] data;
        logic        last;
        int          cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             busy;
    logic             done;
    logic [RAW*CN-1:0] row_rdaddr;
    logic [CN-1:0]    row_rd_en;
    logic [DW*CN-1:0] row_data_in = '0;

    mm_result_reader_if #(.DATA_WIDTH(DW), .COL_NUM(CN), .ROW_ADDR_WIDTH(RAW)) out_if ();

    mm_result_reader #(
        .DATA_WIDTH (DW),
        .ROW_NUM    (RN),
        .COL_NUM    (CN)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .row_rdaddr  (row_rdaddr),
        .row_rd_en   (row_rd_en),
        .row_data_in (row_data_in),
        .out_if      (out_if)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   start_cyc = 0;
    int   rdy_mode = 0;
    int   checks = 0;
    int   failures = 0;
    int   issue_cnt = 0;
    int   outstanding = 0;
    exp_t exp_q[$];
    int   done_q[$];
    bit   hold_valid = 1'b0;
    logic [34:0] held;

    always @(posedge clk) cyc <= cyc + 1;

    // Each bank answers one cycle after its read enable with 16*row + bank.
    always_ff @(posedge clk) begin
        for (int i = 0; i < CN; i++) begin
            if (row_rd_en[i]) begin
                row_data_in[i*DW +: DW] <= 8'(16 * int'(row_rdaddr[i*RAW +: RAW]) + i);
            end
        end
    end

    function automatic logic [31:0] row_data(input int r);
        return {8'(16*r+3), 8'(16*r+2), 8'(16*r+1), 8'(16*r)};
    endfunction

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void update_rdy();
        int rel;
        rel = cyc - start_cyc;
        case (rdy_mode)
            1:       out_if.out_rdy = (rel > 10);
            2:       out_if.out_rdy = (rel % 2 == 0);
            default: out_if.out_rdy = 1'b1;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        start = 1'b0;
        update_rdy();
    endtask

    // Pulse start for one cycle and queue the rows/done this job should produce.
    task automatic applyStimulus(input int n_rows, input int row_off, input int done_off, input bit expect_done);
        exp_t e;
        step();
        start     = 1'b1;
        start_cyc = cyc;
        issue_cnt = 0;
        update_rdy();
        for (int r = 0; r < n_rows; r++) begin
            e.row  = r;
            e.data = row_data(r);
            e.last = (r == RN - 1);
            e.cyc  = (row_off < 0) ? -1 : start_cyc + row_off + r;
            exp_q.push_back(e);
        end
        if (expect_done) begin
            done_q.push_back((done_off < 0) ? -1 : start_cyc + done_off);
        end
    endtask

    task automatic checkOutput(input string tag);
        check({tag, "_busy"},   64'(busy), 0);
        check({tag, "_done"},   64'(done), 0);
        check({tag, "_val"},    64'(out_if.out_val), 0);
        check({tag, "_last"},   64'(out_if.out_last), 0);
        check({tag, "_rd_en"},  64'(row_rd_en), 0);
        check({tag, "_rdaddr"}, 64'(row_rdaddr), 0);
        check({tag, "_row"},    64'(out_if.out_row), 0);
        check({tag, "_data"},   64'(out_if.out_data), 0);
    endtask

    task automatic wait_jobs(input int limit);
        for (int i = 0; i < limit; i++) begin
            if (exp_q.size() == 0 && done_q.size() == 0) break;
            step();
        end
        check("drain_timeout", 64'(exp_q.size() + done_q.size()), 0);
    endtask

    task automatic step_to_rel(input int rel);
        for (int i = 0; i < 100; i++) begin
            if (cyc - start_cyc >= rel) break;
            step();
        end
    endtask

    // Monitor: pops the scoreboard on every handshake and polices issue/hold/done rules.
    always @(negedge clk) begin
        exp_t e;
        logic [RAW*CN-1:0] ea;
        if (!reset) begin
            outstanding = 0;
            issue_cnt   = 0;
            hold_valid  = 1'b0;
        end else begin
            if (row_rd_en != '0) begin
                ea = {CN{issue_cnt[RAW-1:0]}};
                check("rd_en_all_banks", 64'(row_rd_en), 64'hF);
                check("rd_addr", 64'(row_rdaddr), 64'(ea));
                check("credit_limit", 64'(outstanding < 3), 1);
                outstanding++;
                issue_cnt++;
            end
            if (hold_valid) begin
                check("hold_val", 64'(out_if.out_val), 1);
                check("hold_payload", 64'({out_if.out_last, out_if.out_row, out_if.out_data}), 64'(held));
            end
            hold_valid = 1'b0;
            if (out_if.out_val && out_if.out_rdy) begin
                outstanding--;
                if (exp_q.size() == 0) begin
                    check("unexpected_row", 64'(out_if.out_row), 64'hFF);
                end else begin
                    e = exp_q.pop_front();
                    check("row_index", 64'(out_if.out_row), 64'(e.row));
                    check("row_data", 64'(out_if.out_data), 64'(e.data));
                    check("row_last", 64'(out_if.out_last), 64'(e.last));
                    if (e.cyc >= 0) check("row_cycle", 64'(cyc), 64'(e.cyc));
                end
            end else if (out_if.out_val) begin
                hold_valid = 1'b1;
                held       = {out_if.out_last, out_if.out_row, out_if.out_data};
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    check("unexpected_done", 64'(done), 0);
                end else begin
                    int dc;
                    dc = done_q.pop_front();
                    if (dc >= 0) check("done_cycle", 64'(cyc), 64'(dc));
                    check("done_fifo_empty", 64'(out_if.out_val), 0);
                    check("done_busy_low", 64'(busy), 0);
                end
            end
        end
    end

    initial begin
        reset          = 1'b0;
        start          = 1'b0;
        out_if.out_rdy = 1'b1;
        step();
        step();
        checkOutput("reset");
        reset = 1'b1;
        step();

        // Basic drain with timing landmarks.
        rdy_mode = 0;
        applyStimulus(4, 3, 7, 1'b1);
        step();
        @(negedge clk);
        check("basic_busy_c1", 64'(busy), 1);
        check("basic_rd_en_c1", 64'(row_rd_en), 64'hF);
        step();
        @(negedge clk);
        check("basic_val_c2", 64'(out_if.out_val), 0);
        wait_jobs(40);

        // Backpressure for cycles 3..10.
        rdy_mode = 1;
        applyStimulus(4, 11, 15, 1'b1);
        step_to_rel(10);
        @(negedge clk);
        check("bp_issue_count", 64'(issue_cnt), 3);
        check("bp_head_row", 64'(out_if.out_row), 0);
        wait_jobs(40);

        // Alternating ready.
        rdy_mode = 2;
        applyStimulus(4, -1, -1, 1'b1);
        wait_jobs(60);

        // Start while busy is ignored; start right after done runs again.
        rdy_mode = 0;
        applyStimulus(4, 3, 7, 1'b1);
        step_to_rel(4);
        start = 1'b1;
        step_to_rel(7);
        applyStimulus(4, 3, 7, 1'b1);
        wait_jobs(40);

        // Reset mid-job at cycle 5.
        applyStimulus(2, 3, -1, 1'b0);
        step_to_rel(5);
        reset = 1'b0;
        #1;
        checkOutput("midrst");
        step();
        step();
        reset = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check("midrst_leftover", 64'(exp_q.size()), 0);
        applyStimulus(4, 3, 7, 1'b1);
        wait_jobs(40);

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
